// File: rtl/seven_stage_hazard_tracker_pkg.sv
// Shared types and constants for the seven-stage hazard tracker.
// One tracker entry describes the destination of an instruction that has
// left decode and sits in execute, memory_issue, memory_receive or writeback.
package seven_stage_hazard_tracker_pkg;

  localparam int REG_ADDR_BITS = 5;
  localparam logic [REG_ADDR_BITS-1:0] ZERO_REG = 5'd0;
  localparam int NUM_STAGES = 4;

  // Stage slots inside the shadow array, youngest first.
  localparam int STAGE_E  = 0;
  localparam int STAGE_MI = 1;
  localparam int STAGE_MR = 2;
  localparam int STAGE_WB = 3;

  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR_BITS-1:0] rd;
    logic                     regwrite;
    logic                     is_load;
  } tracker_entry_t;

  // An empty slot: what execute receives when decode is killed or stalled.
  function automatic tracker_entry_t bubble_entry();
    return '0;
  endfunction

endpackage

// File: rtl/seven_stage_hazard_tracker_if.sv
// Decode-side bus of the hazard tracker: decode instruction fields in,
// per-stage hazard flags, load-use stall and scan window indication out.
// master = decode/bypass side, slave = the tracker itself.
interface seven_stage_hazard_tracker_if #(
  parameter int ADDRESS_BITS = 32
);
  import seven_stage_hazard_tracker_pkg::*;

  logic                     decode_valid;
  logic [ADDRESS_BITS-1:0]  decode_pc;
  logic [REG_ADDR_BITS-1:0] decode_rs1;
  logic [REG_ADDR_BITS-1:0] decode_rs2;
  logic [REG_ADDR_BITS-1:0] decode_rd;
  logic                     decode_regwrite;
  logic                     decode_mem_read;

  logic rs1_hazard_execute;
  logic rs1_hazard_memory_issue;
  logic rs1_hazard_memory_receive;
  logic rs1_hazard_writeback;
  logic rs2_hazard_execute;
  logic rs2_hazard_memory_issue;
  logic rs2_hazard_memory_receive;
  logic rs2_hazard_writeback;
  logic true_data_hazard;
  logic stall_decode;
  logic scan_active;

  modport master (
    output decode_valid, decode_pc, decode_rs1, decode_rs2, decode_rd,
           decode_regwrite, decode_mem_read,
    input  rs1_hazard_execute, rs1_hazard_memory_issue,
           rs1_hazard_memory_receive, rs1_hazard_writeback,
           rs2_hazard_execute, rs2_hazard_memory_issue,
           rs2_hazard_memory_receive, rs2_hazard_writeback,
           true_data_hazard, stall_decode, scan_active
  );

  modport slave (
    input  decode_valid, decode_pc, decode_rs1, decode_rs2, decode_rd,
           decode_regwrite, decode_mem_read,
    output rs1_hazard_execute, rs1_hazard_memory_issue,
           rs1_hazard_memory_receive, rs1_hazard_writeback,
           rs2_hazard_execute, rs2_hazard_memory_issue,
           rs2_hazard_memory_receive, rs2_hazard_writeback,
           true_data_hazard, stall_decode, scan_active
  );

endinterface

// File: rtl/seven_stage_hazard_tracker_compare.sv
// Combinational match of one tracked entry against decode's rs1/rs2.
// x0 never matches, so entries with rd==0 are harmless. load_hit flags a
// match on an entry whose data is still in flight from memory.
module seven_stage_hazard_compare
  import seven_stage_hazard_tracker_pkg::*;
(
  input  tracker_entry_t           entry,
  input  logic                     decode_valid,
  input  logic [REG_ADDR_BITS-1:0] rs1,
  input  logic [REG_ADDR_BITS-1:0] rs2,
  output logic                     rs1_hit,
  output logic                     rs2_hit,
  output logic                     load_hit
);

  logic writer;

  // Raw per-source match; priority between stages is the bypass unit's job.
  always_comb begin
    writer   = decode_valid & entry.valid & entry.regwrite;
    rs1_hit  = writer & (rs1 != ZERO_REG) & (entry.rd == rs1);
    rs2_hit  = writer & (rs2 != ZERO_REG) & (entry.rd == rs2);
    load_hit = (rs1_hit | rs2_hit) & entry.is_load;
  end

endmodule

// File: rtl/seven_stage_hazard_tracker.sv
// Decode-stage hazard tracker for the seven-stage core. Shadows destination
// info for E/MI/MR/WB, drives raw per-stage hazard flags to the bypass unit,
// and raises the load-use stall while inserting bubbles into execute.
// Optional build macro SEVEN_STAGE_HAZARD_STATS_EN adds the stall_cycles and
// bypass_events saturating counters as extra output ports.
// The scan window (scan enabled and cycle count within range) is exported as
// scan_active so a simulation-side monitor can print the snapshot.
module seven_stage_hazard_tracker
  import seven_stage_hazard_tracker_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int ADDRESS_BITS    = 32,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic freeze,
  input  logic scan,
  seven_stage_hazard_tracker_if.slave bus
`ifdef SEVEN_STAGE_HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] bypass_events
`endif
);

  localparam logic [31:0] SCAN_MIN = 32'(SCAN_CYCLES_MIN);
  localparam logic [31:0] SCAN_MAX = 32'(SCAN_CYCLES_MAX);

  tracker_entry_t            entries [NUM_STAGES];
  logic [NUM_STAGES-1:0]     rs1_hit;
  logic [NUM_STAGES-1:0]     rs2_hit;
  logic [NUM_STAGES-1:0]     load_hit;
  logic                      data_hazard;
  logic                      insert_bubble;
  logic [31:0]               cycle_count;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_compare
    seven_stage_hazard_compare u_compare (
      .entry        (entries[s]),
      .decode_valid (bus.decode_valid),
      .rs1          (bus.decode_rs1),
      .rs2          (bus.decode_rs2),
      .rs1_hit      (rs1_hit[s]),
      .rs2_hit      (rs2_hit[s]),
      .load_hit     (load_hit[s])
    );
  end

  // Load data is only usable from memory_receive onward, so loads in E or MI stall.
  always_comb begin
    data_hazard   = load_hit[STAGE_E] | load_hit[STAGE_MI];
    insert_bubble = flush | data_hazard | ~bus.decode_valid;
  end

  // Drive the bus outputs from the per-stage match vectors.
  always_comb begin
    bus.rs1_hazard_execute        = rs1_hit[STAGE_E];
    bus.rs1_hazard_memory_issue   = rs1_hit[STAGE_MI];
    bus.rs1_hazard_memory_receive = rs1_hit[STAGE_MR];
    bus.rs1_hazard_writeback      = rs1_hit[STAGE_WB];
    bus.rs2_hazard_execute        = rs2_hit[STAGE_E];
    bus.rs2_hazard_memory_issue   = rs2_hit[STAGE_MI];
    bus.rs2_hazard_memory_receive = rs2_hit[STAGE_MR];
    bus.rs2_hazard_writeback      = rs2_hit[STAGE_WB];
    bus.true_data_hazard          = data_hazard;
    bus.stall_decode              = data_hazard | freeze;
    bus.scan_active               = scan & (cycle_count >= SCAN_MIN) &
                                    (cycle_count <= SCAN_MAX);
  end

  // Shadow pipeline: freeze holds everything, otherwise shift and load E.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries <= '{default: '0};
    end else if (!freeze) begin
      entries[STAGE_WB] <= entries[STAGE_MR];
      entries[STAGE_MR] <= entries[STAGE_MI];
      entries[STAGE_MI] <= entries[STAGE_E];
      if (insert_bubble) begin
        entries[STAGE_E] <= bubble_entry();
      end else begin
        entries[STAGE_E] <= '{valid:    1'b1,
                              rd:       bus.decode_rd,
                              regwrite: bus.decode_regwrite,
                              is_load:  bus.decode_mem_read};
      end
    end
  end

  // Free-running cycle counter that defines the scan window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

`ifdef SEVEN_STAGE_HAZARD_STATS_EN
  // Saturating counts of load-use stall cycles and cycles that need a bypass.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles  <= '0;
      bypass_events <= '0;
    end else if (!freeze) begin
      if (data_hazard && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (!data_hazard && ((|rs1_hit) || (|rs2_hit)) &&
          (bypass_events != 32'hFFFF_FFFF)) begin
        bypass_events <= bypass_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seven_stage_hazard_tracker.sv
// Directed scoreboard bench for seven_stage_hazard_tracker. Expected output
// vectors are pushed when a step is driven and popped at the falling edge.
// Vector layout: {rs1 E,MI,MR,WB, rs2 E,MI,MR,WB, true_data_hazard, stall_decode}.
module tb_seven_stage_hazard_tracker;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic freeze = 1'b0;
  logic scan = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [9:0] exp_q [$];
  string      tag_q [$];

`ifdef SEVEN_STAGE_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] bypass_events;
`endif

  seven_stage_hazard_tracker_if #(.ADDRESS_BITS(32)) bus ();

  seven_stage_hazard_tracker #(
    .CORE(0), .ADDRESS_BITS(32), .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .freeze (freeze),
    .scan   (scan),
    .bus    (bus)
`ifdef SEVEN_STAGE_HAZARD_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .bypass_events (bypass_events)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] observed();
    return {bus.rs1_hazard_execute, bus.rs1_hazard_memory_issue,
            bus.rs1_hazard_memory_receive, bus.rs1_hazard_writeback,
            bus.rs2_hazard_execute, bus.rs2_hazard_memory_issue,
            bus.rs2_hazard_memory_receive, bus.rs2_hazard_writeback,
            bus.true_data_hazard, bus.stall_decode};
  endfunction

  task automatic apply_stimulus(input string tag, input logic v,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] d, input logic rw,
                                input logic ld, input logic fl,
                                input logic fz, input logic [9:0] expv);
    bus.decode_valid    = v;
    bus.decode_pc       = bus.decode_pc + 32'd4;
    bus.decode_rs1      = s1;
    bus.decode_rs2      = s2;
    bus.decode_rd       = d;
    bus.decode_regwrite = rw;
    bus.decode_mem_read = ld;
    flush               = fl;
    freeze              = fz;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  task automatic check_output();
    logic [9:0] expv;
    logic [9:0] obs;
    string      tag;
    expv = exp_q.pop_front();
    tag  = tag_q.pop_front();
    obs  = observed();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One cycle: drive after the rising edge, compare at the falling edge.
  task automatic step(input string tag, input logic v,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic rw, input logic ld,
                      input logic fl, input logic fz, input logic [9:0] expv);
    apply_stimulus(tag, v, s1, s2, d, rw, ld, fl, fz, expv);
    @(negedge clock);
    check_output();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.decode_pc = '0;
    // Reset held with a live decode that would otherwise match.
    step("reset_0", 1, 5, 5, 5, 1, 1, 0, 0, 10'b00000_00000);
    step("reset_1", 1, 5, 5, 5, 1, 1, 0, 0, 10'b00000_00000);
    reset = 1'b1;
    step("idle", 0, 5, 5, 5, 1, 0, 0, 0, 10'b00000_00000);

    // ALU producer rd=5 followed by consumers as it moves down the pipe.
    step("add_rd5", 1, 0, 0, 5, 1, 0, 0, 0, 10'b00000_00000);
    step("use_e", 1, 5, 5, 10, 0, 0, 0, 0, 10'b10001_00000);
    step("use_mi", 1, 5, 5, 10, 0, 0, 0, 0, 10'b01000_10000);
    step("use_mr", 1, 5, 0, 0, 0, 0, 0, 0, 10'b00100_00000);
    step("use_wb", 1, 0, 5, 0, 0, 0, 0, 0, 10'b00000_00100);

    // Load-use: two stall cycles, then bypass from memory_receive.
    step("load_rd7", 1, 0, 0, 7, 1, 1, 0, 0, 10'b00000_00000);
    step("lu_e", 1, 7, 0, 8, 1, 0, 0, 0, 10'b10000_00011);
    step("lu_mi", 1, 7, 0, 8, 1, 0, 0, 0, 10'b01000_00011);
    step("lu_mr", 1, 7, 0, 8, 1, 0, 0, 0, 10'b00100_00000);

    // x0 destination never matches.
    step("rd0_wr", 1, 0, 0, 0, 1, 0, 0, 0, 10'b00000_00000);
    step("rs_x0", 1, 0, 0, 0, 0, 0, 0, 0, 10'b00000_00000);

    // Freeze holds a load in E; the hazard persists.
    step("load_rd3", 1, 0, 0, 3, 1, 1, 0, 0, 10'b00000_00000);
    step("frz_0", 1, 3, 0, 4, 1, 0, 0, 1, 10'b10000_00011);
    step("frz_1", 1, 3, 0, 4, 1, 0, 0, 1, 10'b10000_00011);
    step("frz_2", 1, 3, 0, 4, 1, 0, 0, 1, 10'b10000_00011);
`ifdef SEVEN_STAGE_HAZARD_STATS_EN
    check_value("stall_cnt_frz", stall_cycles, 32'd2);
    check_value("bypass_cnt_frz", bypass_events, 32'd5);
`endif
    step("unfrz_e", 1, 3, 0, 4, 1, 0, 0, 0, 10'b10000_00011);
    step("unfrz_mi", 1, 3, 0, 4, 1, 0, 0, 0, 10'b01000_00011);
`ifdef SEVEN_STAGE_HAZARD_STATS_EN
    check_value("stall_cnt", stall_cycles, 32'd4);
`endif

    // Flush on the same edge as rd=9 leaves a bubble in E.
    step("flush_rd9", 1, 3, 0, 9, 1, 0, 1, 0, 10'b00100_00000);
    step("after_flush", 1, 9, 0, 0, 0, 0, 0, 0, 10'b00000_00000);
`ifdef SEVEN_STAGE_HAZARD_STATS_EN
    check_value("bypass_cnt", bypass_events, 32'd6);
`endif

    // Flush together with a load-use hazard; load then seen in MI for one stall.
    step("load_rd12", 1, 0, 0, 12, 1, 1, 0, 0, 10'b00000_00000);
    step("flush_lu", 1, 0, 12, 6, 1, 0, 1, 0, 10'b00001_00011);
    step("lu2_mi", 1, 0, 12, 6, 1, 0, 0, 0, 10'b00000_10011);
    step("lu2_mr", 1, 0, 12, 6, 1, 0, 0, 0, 10'b00000_01000);

    // Scan window is open at the start of the run.
    scan = 1'b1;
    #1;
    check_value("scan_on", {31'd0, bus.scan_active}, 32'd1);
    scan = 1'b0;
    #1;
    check_value("scan_off", {31'd0, bus.scan_active}, 32'd0);

    // Reset asserted in the middle of a load-use stall clears at once.
    @(posedge clock);
    #1;
    step("load_rd13", 1, 0, 0, 13, 1, 1, 0, 0, 10'b00000_00000);
    apply_stimulus("lu3_e", 1, 13, 0, 0, 0, 0, 0, 0, 10'b10000_00011);
    @(negedge clock);
    check_output();
    #1;
    reset = 1'b0;
    #1;
    check_value("async_rst_hazard", {22'd0, observed()}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
